// File: rtl/controle_entrada_pkg.sv
// controle_entrada_pkg: state encodings and shared constants for the IN instruction input stage
package controle_entrada_pkg;
  typedef enum logic [2:0] {
    EST_OCIOSO       = 3'd0,
    EST_ARMAR        = 3'd1,
    EST_ESPERA_PRESS = 3'd2,
    EST_ESPERA_SOLTA = 3'd3,
    EST_COMMIT       = 3'd4,
    EST_INTERVALO    = 3'd5
  } estado_t;
  localparam logic [4:0] OPCODE_IN = 5'd19;
  localparam int DEBOUNCE_PADRAO = 500000;
endpackage

// File: rtl/controle_entrada_debounce.sv
// debounce_botao: two-flop synchroniser plus stable-level debouncer for the confirm button
module debounce_botao import controle_entrada_pkg::*; #(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter bit ATIVO_BAIXO = 1'b1
)(
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic nivel,
  output logic pressEvt,
  output logic relEvt
);
  localparam int LC = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [LC-1:0] LIMITE = LC'(DEBOUNCE_CICLOS - 1);
  logic [1:0] sinc;
  logic [LC-1:0] contador;
  logic sincNivel, vira;
  assign sincNivel = sinc[1] ^ ATIVO_BAIXO;
  assign vira = (sincNivel != nivel) && (contador == LIMITE);
  // synchroniser resets to the raw "released" level so no phantom press follows reset
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sinc <= {2{ATIVO_BAIXO}};
      contador <= '0;
      nivel <= 1'b0;
      pressEvt <= 1'b0;
      relEvt <= 1'b0;
    end else begin
      sinc <= {sinc[0], botao};
      contador <= (sincNivel == nivel || vira) ? '0 : contador + 1'b1;
      nivel <= nivel ^ vira;
      pressEvt <= vira && sincNivel;
      relEvt <= vira && !sincNivel;
    end
endmodule

// File: rtl/controle_entrada.sv
// controle_entrada: IN-instruction handshake between operator button/switches and the control unit
module controle_entrada import controle_entrada_pkg::*; #(
  parameter int LARGURA_SWITCH = 16,
  parameter int LARGURA_DADO = 32,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter bit BOTAO_ATIVO_BAIXO = 1'b1
)(
  input  logic clock,
  input  logic reset,
  input  logic estagioEntradaUC,
  input  logic botaoConfirma,
  input  logic [LARGURA_SWITCH-1:0] switches,
  output logic estagioEntradaSwitch,
  output logic estagioEntradaBanco,
  output logic [LARGURA_DADO-1:0] dadoEntrada,
  output logic entradaAguardando
);
  estado_t estado, proximo;
  logic [LARGURA_SWITCH-1:0] swSinc1, swSinc2;
  logic nivel, pressEvt, relEvt, captura;
  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
    .ATIVO_BAIXO(BOTAO_ATIVO_BAIXO)
  ) uDebounce (
    .clock(clock),
    .reset(reset),
    .botao(botaoConfirma),
    .nivel(nivel),
    .pressEvt(pressEvt),
    .relEvt(relEvt)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado <= EST_OCIOSO;
      swSinc1 <= '0;
      swSinc2 <= '0;
      dadoEntrada <= '0;
    end else begin
      estado <= proximo;
      swSinc1 <= switches;
      swSinc2 <= swSinc1;
      if (captura) dadoEntrada <= LARGURA_DADO'(swSinc2);
    end
  // a request drop always wins over a same-cycle button event
  always_comb begin
    proximo = estado;
    captura = 1'b0;
    case (estado)
      EST_OCIOSO:       proximo = estagioEntradaUC ? EST_ARMAR : EST_OCIOSO;
      EST_ARMAR:        proximo = !estagioEntradaUC ? EST_OCIOSO : (nivel ? EST_ARMAR : EST_ESPERA_PRESS);
      EST_ESPERA_PRESS: begin
        captura = estagioEntradaUC && pressEvt;
        proximo = !estagioEntradaUC ? EST_OCIOSO : (pressEvt ? EST_ESPERA_SOLTA : EST_ESPERA_PRESS);
      end
      EST_ESPERA_SOLTA: proximo = !estagioEntradaUC ? EST_OCIOSO : (relEvt ? EST_COMMIT : EST_ESPERA_SOLTA);
      EST_COMMIT:       proximo = EST_INTERVALO;
      default:          proximo = EST_OCIOSO;
    endcase
  end
  assign estagioEntradaSwitch = (estado == EST_ESPERA_SOLTA) || (estado == EST_COMMIT);
  assign estagioEntradaBanco = (estado == EST_COMMIT);
  assign entradaAguardando = (estado == EST_ARMAR) || (estado == EST_ESPERA_PRESS) || (estado == EST_ESPERA_SOLTA);
endmodule

// File: tb/tb_controle_entrada.sv
// tb_controle_entrada: directed and random stimulus against a stable-window behavioural model
module tb_controle_entrada;
  localparam int DEB = 4;
  logic clock = 1'b0, reset = 1'b1, req = 1'b0, btn = 1'b0;
  logic [15:0] sw = '0;
  logic estagioEntradaSwitch, estagioEntradaBanco, entradaAguardando;
  logic [31:0] dadoEntrada;
  int nChecks = 0, nOk = 0, ciclo = 0, swRise = 0, swRises = 0, bancoAt = 0, bancoCount = 0;
  int t0, s0, b0, primeiro;
  logic prevSw = 1'b0;
  int fase;
  logic acc, evP, evR;
  logic [31:0] mDado;
  logic hb [0:DEB];
  logic [15:0] hs [0:1];

  always #5 clock = ~clock;

  controle_entrada #(.LARGURA_SWITCH(16), .LARGURA_DADO(32), .DEBOUNCE_CICLOS(DEB), .BOTAO_ATIVO_BAIXO(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .estagioEntradaUC(req),
    .botaoConfirma(~btn),
    .switches(sw),
    .estagioEntradaSwitch(estagioEntradaSwitch),
    .estagioEntradaBanco(estagioEntradaBanco),
    .dadoEntrada(dadoEntrada),
    .entradaAguardando(entradaAguardando)
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nOk++;
    else $display("FAIL %s: obtido %h esperado %h (ciclo %0d)", tag, obs, exp, ciclo);
  endtask

  task automatic zeraModelo;
    fase = 0; acc = 0; evP = 0; evR = 0; mDado = '0; prevSw = 0;
    for (int i = 0; i <= DEB; i++) hb[i] = 0;
    hs[0] = '0; hs[1] = '0;
  endtask

  // phases: 0 idle, 1 arm, 2 wait press, 3 wait release, 4 commit, 5 gap
  // the button is accepted once its last DEB synchronised samples all disagree with the accepted level
  task automatic bordaModelo;
    int nf;
    logic vira;
    nf = fase;
    case (fase)
      0: nf = req ? 1 : 0;
      1: nf = !req ? 0 : (acc ? 1 : 2);
      2: if (!req) nf = 0; else if (evP) begin nf = 3; mDado = {16'h0, hs[1]}; end
      3: nf = !req ? 0 : (evR ? 4 : 3);
      4: nf = 5;
      default: nf = 0;
    endcase
    fase = nf;
    vira = 1;
    for (int i = 1; i <= DEB; i++) if (hb[i] == acc) vira = 0;
    evP = vira && !acc;
    evR = vira && acc;
    acc = acc ^ vira;
    for (int i = DEB; i > 0; i--) hb[i] = hb[i-1];
    hb[0] = btn;
    hs[1] = hs[0];
    hs[0] = sw;
  endtask

  task automatic passo;
    @(posedge clock);
    ciclo++;
    bordaModelo();
    #1;
    confere("switch", estagioEntradaSwitch, (fase == 3 || fase == 4));
    confere("banco", estagioEntradaBanco, (fase == 4));
    confere("aguardando", entradaAguardando, (fase >= 1 && fase <= 3));
    confere("dado", dadoEntrada, mDado);
    if (estagioEntradaSwitch && !prevSw) begin swRise = ciclo; swRises++; end
    if (estagioEntradaBanco) begin bancoAt = ciclo; bancoCount++; end
    prevSw = estagioEntradaSwitch;
  endtask

  task automatic rodar(input int n);
    repeat (n) passo();
  endtask

  task automatic pulsoReset;
    #2 reset = 1'b1;
    #1;
    confere("rstSwitch", estagioEntradaSwitch, 0);
    confere("rstBanco", estagioEntradaBanco, 0);
    confere("rstAguardando", entradaAguardando, 0);
    confere("rstDado", dadoEntrada, 0);
    zeraModelo();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    pulsoReset();
    // nominal capture
    req = 1; sw = 16'hA5C3; rodar(3);
    btn = 1; t0 = ciclo; rodar(10);
    confere("latSwitch", swRise - t0, 7);
    btn = 0; t0 = ciclo; b0 = bancoCount; rodar(10);
    confere("latBanco", bancoAt - t0, 7);
    confere("pulsoUnico", bancoCount - b0, 1);
    confere("dadoNominal", dadoEntrada, 32'h0000A5C3);
    req = 0; rodar(3);
    // bounce rejection
    req = 1; sw = 16'h00C8; rodar(3);
    s0 = swRises; b0 = bancoCount;
    repeat (3) begin btn = 1; rodar(3); btn = 0; rodar(2); end
    confere("bounceSemFlag", swRises - s0, 0);
    btn = 1; t0 = ciclo; rodar(10);
    confere("bounceLat", swRise - t0, 7);
    btn = 0; rodar(10);
    confere("bounceUma", swRises - s0, 1);
    confere("bounceCommit", bancoCount - b0, 1);
    req = 0; rodar(3);
    // button held when request arrives
    btn = 1; rodar(10);
    req = 1; sw = 16'h0BEE; s0 = swRises; rodar(10);
    confere("heldSemCaptura", swRises - s0, 0);
    confere("heldAguardando", entradaAguardando, 1);
    btn = 0; rodar(10);
    btn = 1; rodar(10);
    confere("heldFresco", swRises - s0, 1);
    btn = 0; rodar(10);
    confere("heldDado", dadoEntrada, 32'h00000BEE);
    req = 0; rodar(3);
    // abort during wait-for-release
    req = 1; sw = 16'h0F0F; rodar(3);
    btn = 1; rodar(10);
    b0 = bancoCount; req = 0; rodar(1);
    confere("abortSwitch", estagioEntradaSwitch, 0);
    btn = 0; rodar(10);
    confere("abortSemCommit", bancoCount - b0, 0);
    confere("abortDado", dadoEntrada, 32'h00000F0F);
    // async reset mid wait-for-press
    req = 1; sw = 16'h7777; rodar(3);
    btn = 1; rodar(3);
    btn = 0; b0 = bancoCount;
    pulsoReset();
    rodar(12);
    req = 0; rodar(3);
    confere("resetSemCommit", bancoCount - b0, 0);
    // back-to-back IN with request held
    req = 1; sw = 16'h0001; b0 = bancoCount; rodar(3);
    btn = 1; rodar(10);
    sw = 16'hFFFF; btn = 0; rodar(10);
    confere("b2bDado1", dadoEntrada, 32'h00000001);
    confere("b2bPulso1", bancoCount - b0, 1);
    primeiro = bancoAt;
    btn = 1; rodar(10);
    btn = 0; rodar(10);
    confere("b2bDado2", dadoEntrada, 32'h0000FFFF);
    confere("b2bPulso2", bancoCount - b0, 2);
    confere("b2bIntervalo", bancoAt - primeiro, 20);
    req = 0; rodar(3);
    // switch change after press
    req = 1; sw = 16'h5A5A; rodar(3);
    btn = 1; rodar(10);
    sw = 16'h1234; rodar(5);
    btn = 0; rodar(10);
    confere("swMudaDado", dadoEntrada, 32'h00005A5A);
    req = 0; rodar(3);
    // random traffic
    repeat (300) begin
      req = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      sw = 16'($urandom);
      if ($urandom_range(0, 80) == 0) pulsoReset();
      rodar($urandom_range(1, 7));
    end
    $display("%0d/%0d checks passed", nOk, nChecks);
    $finish;
  end
endmodule
